// File: rtl/ball_handoff_sequencer.sv
// rtl/ball_handoff_sequencer.sv - ball ownership handoff between two boards over an I2C link
// Serves, ships the exiting ball to the opponent, loads the returning ball and keeps score.
module ball_handoff_sequencer #(
  parameter int SCORE_MAX          = 5,
  parameter int TX_TIMEOUT         = 2_500_000,
  parameter int LOCAL_SERVES_FIRST = 1
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       game_start,
  input  logic       ball_exit,
  input  logic       miss_detected,
  input  logic [9:0] ball_y_in,
  input  logic [7:0] ball_vy_in,
  input  logic [1:0] gravity_in,
  input  logic [7:0] speed_in,
  input  logic       is_i2c_master_done,
  input  logic       is_slave_done,
  input  logic [7:0] slv_reg0_y0,
  input  logic [7:0] slv_reg1_y1,
  input  logic [7:0] slv_reg2_Yspeed,
  input  logic [7:0] slv_reg3_gravity,
  input  logic [7:0] slv_reg4_ballspeed,
  input  logic [7:0] slv_reg5_win_flag,
  output logic       ball_send_trigger,
  output logic [7:0] tx_y0,
  output logic [7:0] tx_y1,
  output logic [7:0] tx_vy,
  output logic [7:0] tx_gravity,
  output logic [7:0] tx_speed,
  output logic [7:0] tx_flag,
  output logic       load_ball,
  output logic [9:0] load_y,
  output logic [7:0] load_vy,
  output logic [1:0] load_gravity,
  output logic [7:0] load_speed,
  output logic       ball_active,
  output logic       responsing_i2c,
  output logic [3:0] local_score,
  output logic [3:0] remote_score,
  output logic       game_over,
  output logic       is_you_win,
  output logic       timeout_err
);
  localparam int            CW       = $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TX_TIMEOUT - 1);
  localparam logic [3:0]    SMAX     = 4'(SCORE_MAX);

  typedef enum logic [2:0] {IDLE, LOCAL, SEND, WAIT_TX, REMOTE, LOAD, OVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_y0_q, tx_y0_d, tx_y1_q, tx_y1_d, tx_vy_q, tx_vy_d;
  logic [7:0]    tx_gravity_q, tx_gravity_d, tx_speed_q, tx_speed_d, tx_flag_q, tx_flag_d;
  logic          load_ball_q, load_ball_d;
  logic [9:0]    load_y_q, load_y_d;
  logic [7:0]    load_vy_q, load_vy_d, load_speed_q, load_speed_d;
  logic [1:0]    load_gravity_q, load_gravity_d;
  logic          trig_q, trig_d, active_q, active_d, resp_q, resp_d, over_q, over_d;
  logic [3:0]    local_q, local_d, remote_q, remote_d, local_inc, remote_inc;
  logic          win_q, win_d, tmo_err_q, tmo_err_d, over_pend_q, over_pend_d;
  logic          serve;
  logic          unused_bits;

  assign unused_bits = ^{slv_reg1_y1[7:2], slv_reg3_gravity[7:2]};

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    tx_y0_d        = tx_y0_q;
    tx_y1_d        = tx_y1_q;
    tx_vy_d        = tx_vy_q;
    tx_gravity_d   = tx_gravity_q;
    tx_speed_d     = tx_speed_q;
    tx_flag_d      = tx_flag_q;
    load_ball_d    = 1'b0;
    load_y_d       = load_y_q;
    load_vy_d      = load_vy_q;
    load_gravity_d = load_gravity_q;
    load_speed_d   = load_speed_q;
    local_d        = local_q;
    remote_d       = remote_q;
    win_d          = win_q;
    tmo_err_d      = tmo_err_q;
    over_pend_d    = over_pend_q;
    serve          = 1'b0;
    local_inc      = (local_q >= SMAX) ? local_q : local_q + 4'd1;
    remote_inc     = (remote_q >= SMAX) ? remote_q : remote_q + 4'd1;

    case (state_q)
      IDLE, OVER: begin
        if (game_start) begin
          local_d     = '0;
          remote_d    = '0;
          win_d       = 1'b0;
          over_pend_d = 1'b0;
          if (LOCAL_SERVES_FIRST != 0) begin
            state_d = LOCAL;
            serve   = 1'b1;
          end else begin
            state_d = REMOTE;
          end
        end
      end
      LOCAL: begin
        // A miss ends the rally, so any exit pulse in the same cycle is stale.
        if (miss_detected) begin
          remote_d  = remote_inc;
          tx_flag_d = (remote_inc == SMAX) ? 8'h02 : 8'h01;
          state_d   = SEND;
        end else if (ball_exit) begin
          tx_y0_d      = ball_y_in[7:0];
          tx_y1_d      = {6'b0, ball_y_in[9:8]};
          tx_vy_d      = ball_vy_in;
          tx_gravity_d = {6'b0, gravity_in};
          tx_speed_d   = speed_in;
          tx_flag_d    = 8'h00;
          state_d      = SEND;
        end
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (is_i2c_master_done) begin
          if (tx_flag_q == 8'h02) begin
            state_d = OVER;
            win_d   = 1'b0;
          end else begin
            state_d = REMOTE;
          end
        end else if (cnt_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REMOTE: begin
        if (is_slave_done) begin
          state_d = LOAD;
          case (slv_reg5_win_flag)
            8'h01: begin
              local_d     = local_inc;
              over_pend_d = 1'b0;
              serve       = 1'b1;
            end
            8'h02: begin
              local_d     = local_inc;
              over_pend_d = 1'b1;
            end
            default: begin
              over_pend_d    = 1'b0;
              load_ball_d    = 1'b1;
              load_y_d       = {slv_reg1_y1[1:0], slv_reg0_y0};
              load_vy_d      = slv_reg2_Yspeed;
              load_gravity_d = slv_reg3_gravity[1:0];
              load_speed_d   = slv_reg4_ballspeed;
            end
          endcase
        end
      end
      LOAD: begin
        if (over_pend_q) begin
          state_d = OVER;
          win_d   = 1'b1;
        end else begin
          state_d = LOCAL;
        end
      end
      default: state_d = IDLE;
    endcase

    if (serve) begin
      load_ball_d    = 1'b1;
      load_y_d       = 10'd240;
      load_vy_d      = 8'd0;
      load_gravity_d = 2'd0;
      load_speed_d   = 8'd4;
    end

    // State-decoded outputs are computed from the next state so they are flops aligned with it.
    trig_d   = (state_d == SEND);
    active_d = (state_d == LOCAL);
    resp_d   = (state_d == LOAD);
    over_d   = (state_d == OVER);
  end

  always_ff @(posedge clk_25MHZ or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tx_y0_q        <= '0;
      tx_y1_q        <= '0;
      tx_vy_q        <= '0;
      tx_gravity_q   <= '0;
      tx_speed_q     <= '0;
      tx_flag_q      <= '0;
      load_ball_q    <= 1'b0;
      load_y_q       <= '0;
      load_vy_q      <= '0;
      load_gravity_q <= '0;
      load_speed_q   <= '0;
      trig_q         <= 1'b0;
      active_q       <= 1'b0;
      resp_q         <= 1'b0;
      over_q         <= 1'b0;
      local_q        <= '0;
      remote_q       <= '0;
      win_q          <= 1'b0;
      tmo_err_q      <= 1'b0;
      over_pend_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tx_y0_q        <= tx_y0_d;
      tx_y1_q        <= tx_y1_d;
      tx_vy_q        <= tx_vy_d;
      tx_gravity_q   <= tx_gravity_d;
      tx_speed_q     <= tx_speed_d;
      tx_flag_q      <= tx_flag_d;
      load_ball_q    <= load_ball_d;
      load_y_q       <= load_y_d;
      load_vy_q      <= load_vy_d;
      load_gravity_q <= load_gravity_d;
      load_speed_q   <= load_speed_d;
      trig_q         <= trig_d;
      active_q       <= active_d;
      resp_q         <= resp_d;
      over_q         <= over_d;
      local_q        <= local_d;
      remote_q       <= remote_d;
      win_q          <= win_d;
      tmo_err_q      <= tmo_err_d;
      over_pend_q    <= over_pend_d;
    end
  end

  assign ball_send_trigger = trig_q;
  assign tx_y0             = tx_y0_q;
  assign tx_y1             = tx_y1_q;
  assign tx_vy             = tx_vy_q;
  assign tx_gravity        = tx_gravity_q;
  assign tx_speed          = tx_speed_q;
  assign tx_flag           = tx_flag_q;
  assign load_ball         = load_ball_q;
  assign load_y            = load_y_q;
  assign load_vy           = load_vy_q;
  assign load_gravity      = load_gravity_q;
  assign load_speed        = load_speed_q;
  assign ball_active       = active_q;
  assign responsing_i2c    = resp_q;
  assign local_score       = local_q;
  assign remote_score      = remote_q;
  assign game_over         = over_q;
  assign is_you_win        = win_q;
  assign timeout_err       = tmo_err_q;
endmodule

// File: tb/tb_ball_handoff_sequencer.sv
// tb/tb_ball_handoff_sequencer.sv - self-checking bench for ball_handoff_sequencer
// Expected payloads and loads are queued at stimulus time and popped when the DUT pulses.
module tb_ball_handoff_sequencer;
  localparam int SMAX = 2;
  localparam int TMO  = 8;

  logic       clk_25MHZ = 1'b0;
  logic       reset = 1'b1;
  logic       game_start = 1'b0, ball_exit = 1'b0, miss_detected = 1'b0;
  logic [9:0] ball_y_in = '0;
  logic [7:0] ball_vy_in = '0, speed_in = '0;
  logic [1:0] gravity_in = '0;
  logic       is_i2c_master_done = 1'b0, is_slave_done = 1'b0;
  logic [7:0] slv_reg0_y0 = '0, slv_reg1_y1 = '0, slv_reg2_Yspeed = '0;
  logic [7:0] slv_reg3_gravity = '0, slv_reg4_ballspeed = '0, slv_reg5_win_flag = '0;
  logic       ball_send_trigger, load_ball, ball_active, responsing_i2c;
  logic [7:0] tx_y0, tx_y1, tx_vy, tx_gravity, tx_speed, tx_flag;
  logic [9:0] load_y;
  logic [7:0] load_vy, load_speed;
  logic [1:0] load_gravity;
  logic [3:0] local_score, remote_score;
  logic       game_over, is_you_win, timeout_err;

  ball_handoff_sequencer #(.SCORE_MAX(SMAX), .TX_TIMEOUT(TMO), .LOCAL_SERVES_FIRST(1)) dut (
    .clk_25MHZ(clk_25MHZ), .reset(reset), .game_start(game_start), .ball_exit(ball_exit),
    .miss_detected(miss_detected), .ball_y_in(ball_y_in), .ball_vy_in(ball_vy_in),
    .gravity_in(gravity_in), .speed_in(speed_in), .is_i2c_master_done(is_i2c_master_done),
    .is_slave_done(is_slave_done), .slv_reg0_y0(slv_reg0_y0), .slv_reg1_y1(slv_reg1_y1),
    .slv_reg2_Yspeed(slv_reg2_Yspeed), .slv_reg3_gravity(slv_reg3_gravity),
    .slv_reg4_ballspeed(slv_reg4_ballspeed), .slv_reg5_win_flag(slv_reg5_win_flag),
    .ball_send_trigger(ball_send_trigger), .tx_y0(tx_y0), .tx_y1(tx_y1), .tx_vy(tx_vy),
    .tx_gravity(tx_gravity), .tx_speed(tx_speed), .tx_flag(tx_flag), .load_ball(load_ball),
    .load_y(load_y), .load_vy(load_vy), .load_gravity(load_gravity), .load_speed(load_speed),
    .ball_active(ball_active), .responsing_i2c(responsing_i2c), .local_score(local_score),
    .remote_score(remote_score), .game_over(game_over), .is_you_win(is_you_win),
    .timeout_err(timeout_err)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;

  logic [47:0] tx_vec;
  logic [27:0] ld_vec;
  logic [90:0] all_outs;
  assign tx_vec = {tx_y0, tx_y1, tx_vy, tx_gravity, tx_speed, tx_flag};
  assign ld_vec = {load_y, load_vy, load_gravity, load_speed};
  assign all_outs = {ball_send_trigger, tx_vec, load_ball, ld_vec, ball_active, responsing_i2c,
                     local_score, remote_score, game_over, is_you_win, timeout_err};

  localparam logic [27:0] SERVE_LD = {10'd240, 8'd0, 2'd0, 8'd4};

  int          tests_run = 0;
  int          failed = 0;
  logic [47:0] exp_tx_q[$];
  logic [27:0] exp_ld_q[$];
  logic [47:0] last_tx;

  task automatic step();
    @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic wait_trig(output bit ok);
    int n = 0;
    while (!ball_send_trigger && n < 40) begin
      step();
      n++;
    end
    ok = ball_send_trigger;
  endtask

  task automatic check_tx_pulse(input string name);
    bit          ok;
    logic [47:0] e;
    wait_trig(ok);
    e = (exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 48'hx;
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL %s_trigger: trigger=%0b required 1 within 40 cycles", name, ball_send_trigger);
    end else if (tx_vec !== e) begin
      failed++;
      $display("FAIL %s_payload: tx=%h required %h", name, tx_vec, e);
    end
  endtask

  task automatic exit_round(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                            input logic [7:0] s);
    ball_y_in = y; ball_vy_in = vy; gravity_in = g; speed_in = s;
    last_tx = {y[7:0], 6'b0, y[9:8], vy, 6'b0, g, s, 8'h00};
    exp_tx_q.push_back(last_tx);
    ball_exit = 1'b1; step(); ball_exit = 1'b0;
    check_tx_pulse("exit");
    step();
    tests_run++;
    if (ball_send_trigger !== 1'b0) begin
      failed++;
      $display("FAIL trigger_width: trigger=%0b required 0", ball_send_trigger);
    end
    is_i2c_master_done = 1'b1; step(); is_i2c_master_done = 1'b0;
    tests_run++;
    if ({ball_active, game_over} !== 2'b00) begin
      failed++;
      $display("FAIL done_to_remote: active,over=%b required 00", {ball_active, game_over});
    end
  endtask

  task automatic slave_round(input logic [7:0] flag, input logic [7:0] y0, y1, vy, g, s,
                             input logic exp_lb, input logic [27:0] exp_ld);
    logic [27:0] e;
    slv_reg0_y0 = y0; slv_reg1_y1 = y1; slv_reg2_Yspeed = vy;
    slv_reg3_gravity = g; slv_reg4_ballspeed = s; slv_reg5_win_flag = flag;
    if (exp_lb) exp_ld_q.push_back(exp_ld);
    is_slave_done = 1'b1; step(); is_slave_done = 1'b0;
    tests_run++;
    if ({responsing_i2c, load_ball} !== {1'b1, exp_lb}) begin
      failed++;
      $display("FAIL load_pulse: resp,load=%b required %b", {responsing_i2c, load_ball}, {1'b1, exp_lb});
    end
    if (exp_lb && load_ball) begin
      e = (exp_ld_q.size() != 0) ? exp_ld_q.pop_front() : 28'hx;
      tests_run++;
      if (ld_vec !== e) begin
        failed++;
        $display("FAIL load_values: load=%h required %h", ld_vec, e);
      end
    end
    step();
    tests_run++;
    if ({responsing_i2c, load_ball} !== 2'b00) begin
      failed++;
      $display("FAIL load_width: resp,load=%b required 00", {responsing_i2c, load_ball});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #5; reset = 1'b0;
    repeat (3) step();
    tests_run++;
    if (all_outs !== '0) begin failed++; $display("FAIL reset_outputs: %h required 0", all_outs); end
    reset = 1'b1;
    step();
    tests_run++;
    if (all_outs !== '0) begin failed++; $display("FAIL idle_outputs: %h required 0", all_outs); end
  endtask

  task automatic test_serve();
    logic [27:0] e;
    exp_ld_q.push_back(SERVE_LD);
    game_start = 1'b1; step(); game_start = 1'b0;
    e = exp_ld_q.pop_front();
    tests_run++;
    if ({load_ball, ld_vec, ball_active} !== {1'b1, e, 1'b1}) begin
      failed++;
      $display("FAIL serve: load=%0b vals=%h active=%0b required 1 %h 1", load_ball, ld_vec, ball_active, e);
    end
    step();
    tests_run++;
    if ({load_ball, ball_active} !== 2'b01) begin
      failed++;
      $display("FAIL serve_pulse: load,active=%b required 01", {load_ball, ball_active});
    end
  endtask

  task automatic test_exit_and_remote_load();
    exit_round(10'h2A5, 8'hFD, 2'd1, 8'd6);
    slave_round(8'h00, 8'h10, 8'h01, 8'h22, 8'hFE, 8'h05, 1'b1, {10'h110, 8'h22, 2'd2, 8'h05});
    tests_run++;
    if (ball_active !== 1'b1) begin failed++; $display("FAIL remote_to_local: active=%0b required 1", ball_active); end
  endtask

  task automatic test_ignored_inputs();
    is_slave_done = 1'b1; game_start = 1'b1; step(); is_slave_done = 1'b0; game_start = 1'b0;
    tests_run++;
    if ({responsing_i2c, load_ball, ball_active} !== 3'b001) begin
      failed++;
      $display("FAIL ignored_in_local: resp,load,active=%b required 001", {responsing_i2c, load_ball, ball_active});
    end
  endtask

  task automatic test_unknown_flag();
    exit_round(10'h155, 8'h03, 2'd2, 8'd9);
    slave_round(8'h7F, 8'h34, 8'hFE, 8'h80, 8'h03, 8'h0C, 1'b1, {10'h234, 8'h80, 2'd3, 8'h0C});
  endtask

  task automatic test_miss_exit_timeout();
    int n = 0;
    ball_y_in = 10'h3FF; ball_vy_in = 8'h11; gravity_in = 2'd3; speed_in = 8'h22;
    last_tx = {last_tx[47:8], 8'h01};
    exp_tx_q.push_back(last_tx);
    miss_detected = 1'b1; ball_exit = 1'b1; step(); miss_detected = 1'b0; ball_exit = 1'b0;
    check_tx_pulse("miss_exit");
    tests_run++;
    if ({remote_score, timeout_err} !== {4'd1, 1'b0}) begin
      failed++;
      $display("FAIL miss_score: remote=%0d tmo=%0b required 1 0", remote_score, timeout_err);
    end
    do begin step(); n++; end while (!ball_send_trigger && n < 30);
    tests_run++;
    if (n !== 9) begin failed++; $display("FAIL retrigger_period: %0d cycles required 9", n); end
    tests_run++;
    if ({timeout_err, tx_vec} !== {1'b1, last_tx}) begin
      failed++;
      $display("FAIL resend: tmo=%0b tx=%h required 1 %h", timeout_err, tx_vec, last_tx);
    end
    step();
    is_i2c_master_done = 1'b1; step(); is_i2c_master_done = 1'b0;
    slave_round(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, SERVE_LD);
    tests_run++;
    if ({local_score, ball_active} !== {4'd1, 1'b1}) begin
      failed++;
      $display("FAIL point_serve: local=%0d active=%0b required 1 1", local_score, ball_active);
    end
  endtask

  task automatic test_game_over_lose();
    last_tx = {last_tx[47:8], 8'h02};
    exp_tx_q.push_back(last_tx);
    miss_detected = 1'b1; step(); miss_detected = 1'b0;
    check_tx_pulse("final_miss");
    step();
    is_i2c_master_done = 1'b1; step(); is_i2c_master_done = 1'b0;
    tests_run++;
    if ({remote_score, game_over, is_you_win, ball_active} !== {4'd2, 3'b100}) begin
      failed++;
      $display("FAIL lose: remote=%0d over=%0b win=%0b active=%0b required 2 1 0 0",
               remote_score, game_over, is_you_win, ball_active);
    end
    is_slave_done = 1'b1; step(); is_slave_done = 1'b0;
    tests_run++;
    if ({responsing_i2c, game_over} !== 2'b01) begin
      failed++;
      $display("FAIL slave_in_over: resp,over=%b required 01", {responsing_i2c, game_over});
    end
  endtask

  task automatic test_win();
    exp_ld_q.push_back(SERVE_LD);
    game_start = 1'b1; step(); game_start = 1'b0;
    tests_run++;
    if ({load_ball, ld_vec, local_score, remote_score, game_over} !== {1'b1, exp_ld_q.pop_front(), 8'h00, 1'b0}) begin
      failed++;
      $display("FAIL restart: load=%0b vals=%h local=%0d remote=%0d over=%0b",
               load_ball, ld_vec, local_score, remote_score, game_over);
    end
    exit_round(10'h001, 8'h7F, 2'd0, 8'd3);
    slave_round(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, SERVE_LD);
    exit_round(10'h200, 8'h80, 2'd1, 8'd8);
    slave_round(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, '0);
    tests_run++;
    if ({local_score, game_over, is_you_win} !== {4'd2, 2'b11}) begin
      failed++;
      $display("FAIL win: local=%0d over=%0b win=%0b required 2 1 1", local_score, game_over, is_you_win);
    end
  endtask

  task automatic test_reset_in_wait();
    game_start = 1'b1; step(); game_start = 1'b0;
    tests_run++;
    if ({is_you_win, ball_active} !== 2'b01) begin
      failed++;
      $display("FAIL restart_clears_win: win,active=%b required 01", {is_you_win, ball_active});
    end
    ball_exit = 1'b1; step(); ball_exit = 1'b0;
    step();
    #5 reset = 1'b0;
    #1;
    tests_run++;
    if (all_outs !== '0) begin failed++; $display("FAIL reset_in_wait: %h required 0", all_outs); end
    repeat (2) step();
    #10 reset = 1'b1;
    step();
    game_start = 1'b1; step(); game_start = 1'b0;
    tests_run++;
    if ({load_ball, ball_active, load_y} !== {2'b11, 10'd240}) begin
      failed++;
      $display("FAIL start_after_reset: load=%0b active=%0b y=%0d required 1 1 240", load_ball, ball_active, load_y);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_serve();
    test_exit_and_remote_load();
    test_ignored_inputs();
    test_unknown_flag();
    test_miss_exit_timeout();
    test_game_over_lose();
    test_win();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule

// File: doc/ball_handoff_sequencer.md
BALL_HANDOFF_SEQUENCER -- requirements
Module: ball_handoff_sequencer

Interface
REQ-001 The block SHALL have parameter SCORE_MAX, default 5, meaning points needed to win a match (1..15).
REQ-002 The block SHALL have parameter TX_TIMEOUT, default 2_500_000, meaning the cycle limit for waiting on I2C master completion.
REQ-003 The block SHALL have parameter LOCAL_SERVES_FIRST, default 1, meaning the local board owns the ball after game_start.
REQ-004 The block SHALL have these ports:
- clk_25MHZ  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- game_start  in  1  1-cycle start pulse.
- ball_exit  in  1  1-cycle pulse: local ball left the screen toward the opponent.
- miss_detected  in  1  1-cycle pulse: ball passed the local paddle.
- ball_y_in  in  10  ball y at exit.
- ball_vy_in  in  8  signed y speed at exit.
- gravity_in  in  2  gravity counter at exit.
- speed_in  in  8  x speed at exit.
- is_i2c_master_done  in  1  pulse: master transfer finished.
- is_slave_done  in  1  pulse: slave registers fully written.
- slv_reg0_y0 .. slv_reg5_win_flag  in  8 each  received y[7:0], y[9:8], vy, gravity, speed, flag.
- ball_send_trigger  out  1  1-cycle pulse starting the I2C send.
- tx_y0, tx_y1, tx_vy, tx_gravity, tx_speed, tx_flag  out  8 each  send payload.
- load_ball  out  1  1-cycle pulse: local controller loads a ball.
- load_y  out  10; load_vy  out  8; load_gravity  out  2; load_speed  out  8  loaded ball state.
- ball_active  out  1  local board owns the ball.
- responsing_i2c  out  1  receive acknowledge.
- local_score, remote_score  out  4 each  points.
- game_over  out  1; is_you_win  out  1; timeout_err  out  1 (sticky).

Function
REQ-005 The FSM SHALL have states IDLE, LOCAL, SEND, WAIT_TX, REMOTE, LOAD, OVER.
REQ-006 In IDLE, game_start SHALL clear both scores and go to LOCAL with a serve load (LOCAL_SERVES_FIRST=1), otherwise to REMOTE.
REQ-007 A serve load SHALL pulse load_ball with load_y=240, load_vy=0, load_gravity=0, load_speed=4.
REQ-008 In LOCAL, ball_exit SHALL latch tx_y0=ball_y_in[7:0], tx_y1={6'b0,ball_y_in[9:8]}, tx_vy, tx_gravity={6'b0,gravity_in}, tx_speed, tx_flag=8'h00, then go to SEND.
REQ-009 In LOCAL, miss_detected SHALL increment remote_score and go to SEND with tx_flag=8'h02 if the new value equals SCORE_MAX, else tx_flag=8'h01.
REQ-010 If miss_detected and ball_exit occur in the same cycle, miss_detected SHALL win and ball_exit SHALL be dropped.
REQ-011 SEND SHALL last exactly 1 cycle, asserting ball_send_trigger, then go to WAIT_TX.
REQ-012 tx_* outputs SHALL stay stable from SEND until the next latch.
REQ-013 In WAIT_TX, is_i2c_master_done SHALL go to OVER with is_you_win=0 if tx_flag=8'h02, else to REMOTE.
REQ-014 In WAIT_TX, after TX_TIMEOUT cycles without done, the block SHALL set timeout_err and return to SEND to resend; the counter SHALL clear on entry to WAIT_TX.
REQ-015 In REMOTE, is_slave_done SHALL go to LOAD; is_slave_done in any other state SHALL be ignored.
REQ-016 LOAD SHALL last 1 cycle, asserting responsing_i2c and load_ball, then go to LOCAL.
REQ-017 LOAD with slv_reg5_win_flag=8'h00 SHALL drive load_y={slv_reg1_y1[1:0],slv_reg0_y0}, load_vy=slv_reg2_Yspeed, load_gravity=slv_reg3_gravity[1:0], load_speed=slv_reg4_ballspeed.
REQ-018 LOAD with flag=8'h01 SHALL increment local_score and issue serve values per REQ-007.
REQ-019 LOAD with flag=8'h02 SHALL increment local_score, suppress load_ball, and go to OVER with is_you_win=1.
REQ-020 Any unknown flag value SHALL be treated as 8'h00.
REQ-021 Scores SHALL saturate at SCORE_MAX.
REQ-022 ball_active SHALL be 1 only in LOCAL.
REQ-023 game_over SHALL be 1 only in OVER.
REQ-024 game_start in OVER SHALL behave as in IDLE; game_start in other states SHALL be ignored.

Reset
REQ-025 Asserting reset low at any time SHALL force IDLE and drive all outputs to 0, including scores, tx_* registers, timeout_err, and is_you_win, abandoning any pending transfer.
REQ-026 The first game_start after reset release SHALL be honoured.

Verification
REQ-027 Reset, game_start -> load_ball pulse with y=240, ball_active=1 next cycle.
REQ-028 ball_exit with y=0x2A5, vy=-3 -> tx_y0=0xA5, tx_y1=0x02, tx_vy=0xFD, 1-cycle trigger, then done -> REMOTE.
REQ-029 REMOTE, regs y0=0x10, y1=0x01, flag=0, is_slave_done -> load_y=0x110, responsing_i2c 1 cycle, ball_active=1.
REQ-030 SCORE_MAX=2: two misses -> remote_score=2, tx_flag=0x02, done -> game_over=1, is_you_win=0.
REQ-031 TX_TIMEOUT=8, no done -> trigger re-pulses every 9 cycles, timeout_err=1.
REQ-032 Simultaneous miss+exit -> tx_flag=0x01; reset low in WAIT_TX -> IDLE with all outputs 0.
